// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM family.
//   RDW_WRITE_FIRST / RDW_READ_FIRST : same-port read-during-write modes
//   clr_state_e                      : clear-sequencer states
package ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN
    } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: one IDLE cycle, then (optionally) one full-word
// write per cycle walking every address from 0 upward, then RUN.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   busy         : high in IDLE and CLEAR
//   clr_we       : clear write strobe (CLEAR only)
//   clr_addr     : address being cleared this cycle
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned addr_width_g = 11,
    parameter int          clear_en_g   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    busy,
    output logic                    clr_we,
    output logic [addr_width_g-1:0] clr_addr
);

    clr_state_e              state_q, state_d;
    logic [addr_width_g-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        busy    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                state_d = (clear_en_g != 0) ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + addr_width_g'(1);
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/dpram_clr.sv
// True dual-port RAM with per-port clock enables, byte-lane write enables,
// selectable same-port read-during-write mode and a post-reset clear.
// Ports (B identical to A):
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   a_clken               : port enable; low = no access, a_q holds
//   a_address, a_data     : address / write data
//   a_wren, a_byteena     : write request / per-lane write mask
//   a_q                   : registered read data (one-cycle latency)
//   busy                  : high while the clear sequence runs; ports ignored
module dpram_clr
    import ram_pkg::*;
#(
    parameter int unsigned              addr_width_g  = 11,
    parameter int unsigned              data_width_g  = 8,
    parameter int unsigned              byte_width_g  = 8,
    parameter int                       rdw_mode_g    = RDW_WRITE_FIRST,
    parameter int                       clear_en_g    = 1,
    parameter logic [data_width_g-1:0]  clear_value_g = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 a_clken,
    input  logic [addr_width_g-1:0]              a_address,
    input  logic [data_width_g-1:0]              a_data,
    input  logic                                 a_wren,
    input  logic [data_width_g/byte_width_g-1:0] a_byteena,
    output logic [data_width_g-1:0]              a_q,
    input  logic                                 b_clken,
    input  logic [addr_width_g-1:0]              b_address,
    input  logic [data_width_g-1:0]              b_data,
    input  logic                                 b_wren,
    input  logic [data_width_g/byte_width_g-1:0] b_byteena,
    output logic [data_width_g-1:0]              b_q,
    output logic                                 busy
);

    localparam int unsigned NLANES = data_width_g / byte_width_g;
    localparam int unsigned DEPTH  = 2 ** addr_width_g;

    if ((data_width_g % byte_width_g) != 0) begin : g_bad_width
        $error("dpram_clr: data_width_g must be a multiple of byte_width_g");
    end

    logic [data_width_g-1:0] mem [DEPTH];

    logic                    busy_w, clr_we;
    logic [addr_width_g-1:0] clr_addr;

    logic [addr_width_g-1:0] a_addr_w;
    logic [data_width_g-1:0] a_wdata_w;
    logic [NLANES-1:0]       a_wmask_w, b_wmask_w;
    logic [data_width_g-1:0] a_old, b_old, a_merged, b_merged;
    logic [data_width_g-1:0] a_q_d, b_q_d, a_q_q, b_q_q;

    ram_clear_seq #(
        .addr_width_g (addr_width_g),
        .clear_en_g   (clear_en_g)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy_w),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The clear sequencer borrows port A's write path while busy.
    always_comb begin
        if (busy_w) begin
            a_addr_w  = clr_addr;
            a_wdata_w = clear_value_g;
            a_wmask_w = clr_we ? '1 : '0;
        end else begin
            a_addr_w  = a_address;
            a_wdata_w = a_data;
            a_wmask_w = (a_clken && a_wren) ? a_byteena : '0;
        end
        b_wmask_w = (!busy_w && b_clken && b_wren) ? b_byteena : '0;

        a_old    = mem[a_addr_w];
        b_old    = mem[b_address];
        a_merged = a_old;
        b_merged = b_old;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (a_wmask_w[i]) a_merged[i*byte_width_g +: byte_width_g] = a_wdata_w[i*byte_width_g +: byte_width_g];
            if (b_wmask_w[i]) b_merged[i*byte_width_g +: byte_width_g] = b_data[i*byte_width_g +: byte_width_g];
        end

        // An all-zero mask is a read, so it always returns the stored word.
        a_q_d = (a_wmask_w != '0 && rdw_mode_g == RDW_WRITE_FIRST) ? a_merged : a_old;
        b_q_d = (b_wmask_w != '0 && rdw_mode_g == RDW_WRITE_FIRST) ? b_merged : b_old;
    end

    // Lane-granular writes; port A is issued last so it wins shared lanes.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (b_wmask_w[i]) mem[b_address][i*byte_width_g +: byte_width_g] <= b_data[i*byte_width_g +: byte_width_g];
            if (a_wmask_w[i]) mem[a_addr_w][i*byte_width_g +: byte_width_g] <= a_wdata_w[i*byte_width_g +: byte_width_g];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || busy_w) begin
            a_q_q <= '0;
            b_q_q <= '0;
        end else begin
            if (a_clken) a_q_q <= a_q_d;
            if (b_clken) b_q_q <= b_q_d;
        end
    end

    assign a_q  = a_q_q;
    assign b_q  = b_q_q;
    assign busy = busy_w;

endmodule
